rf_write_arbiter: RTL and testbench

Shares the single write port of the 16×8 signed register file (`reg_file`) between two producers, requester 0 and requester 1 (for example, the ALU result and the load path). It uses a valid/ready handshake and round-robin fairness. It drives the register file's write address, write data and write enable from a registered output stage. It also flags read-after-write hazards for the two read ports while a write is in flight.

---
 rtl/rf_pkg.sv | 32 +++
 rtl/rf_write_arbiter_rr_arb2.sv | 38 +++
 rtl/rf_write_arbiter.sv | 96 +++++++++
 tb/tb_rf_write_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file types and the 2-way round-robin pick helper.
// Used by reg_file, its sequencers and rf_write_arbiter.
package rf_pkg;

  localparam int RF_ADDR_W = 4;
  localparam int RF_DATA_W = 8;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic signed [RF_DATA_W-1:0] rf_data_t;

  typedef struct packed {
    rf_addr_t addr;
    rf_data_t data;
  } rf_wr_t;

  // One-hot grant; a tie goes to the requester named by prio.
  function automatic logic [1:0] rr_pick(
    input logic [1:0] valid,
    input logic       prio
  );
    logic [1:0] g;
    g = 2'b00;
    case (valid)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = prio ? 2'b10 : 2'b01;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_rr_arb2.sv
// Two-way round-robin grant with priority pointer and last-grant index.
// Grants are suppressed while rst_n is low.
module rr_arb2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid_i,
  output logic [1:0] grant_o,
  output logic       last_o
);

  logic prio_q, prio_d;
  logic last_q, last_d;

  always_comb begin
    grant_o = rst_n ? rr_pick(valid_i, prio_q) : 2'b00;
    prio_d  = prio_q;
    last_d  = last_q;
    if (|grant_o) begin
      prio_d = grant_o[0];
      last_d = grant_o[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
      last_q <= last_d;
    end
  end

  assign last_o = last_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: round-robin, registered write, RAW hazards.
// Optional RF_ARB_ZERO_PROTECT_EN makes register 0 read-only.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  input  logic [ADDR_W-1:0]        req0_addr,
  input  logic signed [DATA_W-1:0] req0_data,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [ADDR_W-1:0]        req1_addr,
  input  logic signed [DATA_W-1:0] req1_data,
  output logic                     req1_ready,
  input  logic [ADDR_W-1:0]        rd_addr1,
  input  logic [ADDR_W-1:0]        rd_addr2,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic signed [DATA_W-1:0] wr_data,
  output logic                     wr_en,
  output logic                     hazard1,
  output logic                     hazard2,
  output logic                     last_grant
);

  typedef struct packed {
    logic [ADDR_W-1:0]        addr;
    logic signed [DATA_W-1:0] data;
  } wr_t;

  logic [1:0] grant;
  wr_t        pick;
  wr_t        wr_q, wr_d;
  logic       en_q, en_d;
  logic       zero_blk;
  logic       hz_ok;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i ({req1_valid, req0_valid}),
    .grant_o (grant),
    .last_o  (last_grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    pick = '0;
    unique case (1'b1)
      grant[0]: pick = '{addr: req0_addr, data: req0_data};
      grant[1]: pick = '{addr: req1_addr, data: req1_data};
      default:  pick = '0;
    endcase
`ifdef RF_ARB_ZERO_PROTECT_EN
    zero_blk = (pick.addr == '0);
`else
    zero_blk = 1'b0;
`endif
    wr_d = wr_q;
    en_d = 1'b0;
    if (|grant) begin
      wr_d = pick;
      en_d = !zero_blk;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q <= 1'b0;
      wr_q <= '0;
    end else begin
      en_q <= en_d;
      wr_q <= wr_d;
    end
  end

  // Gating with rst_n cancels a write that is in flight at the reset edge.
  assign wr_en   = en_q & rst_n;
  assign wr_addr = wr_q.addr;
  assign wr_data = wr_q.data;

`ifdef RF_ARB_ZERO_PROTECT_EN
  assign hz_ok = wr_en && (wr_addr != '0);
`else
  assign hz_ok = wr_en;
`endif

  assign hazard1 = hz_ok && (rd_addr1 == wr_addr);
  assign hazard2 = hz_ok && (rd_addr2 == wr_addr);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: vector table, directed
// reset/zero-register sequences, and a randomized run against a model.
module tb_rf_write_arbiter;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0_valid, req1_valid;
  logic [3:0]        req0_addr, req1_addr;
  logic signed [7:0] req0_data, req1_data;
  logic              req0_ready, req1_ready;
  logic [3:0]        rd_addr1, rd_addr2;
  logic [3:0]        wr_addr;
  logic signed [7:0] wr_data;
  logic              wr_en, hazard1, hazard2, last_grant;

  always #5 clk = ~clk;

  rf_write_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rd_addr1   (rd_addr1),
    .rd_addr2   (rd_addr2),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .hazard1    (hazard1),
    .hazard2    (hazard2),
    .last_grant (last_grant)
  );

`ifdef RF_ARB_ZERO_PROTECT_EN
  localparam bit ZP = 1'b1;
`else
  localparam bit ZP = 1'b0;
`endif

  // Stand-in for reg_file: captures on the rising edge when wr_en is high.
  logic signed [7:0] rf [16];
  logic              rf_clr;
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else if (wr_en) begin
      rf[wr_addr] <= wr_data;
    end
  end

  int n_run = 0;
  int n_fail = 0;

  task automatic chk(input string n, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", n, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit                m_en, m_prio, m_last;
  logic [3:0]        m_addr;
  logic signed [7:0] m_data;
  logic signed [7:0] m_mem [16];
  int                m_gnt;

  task automatic model_reset();
    m_en = 0; m_prio = 0; m_last = 0;
    m_addr = '0; m_data = '0; m_gnt = -1;
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
  endtask

  // One cycle: check outputs mid-cycle, then advance model at the edge.
  task automatic tick();
    int g;
    bit e;
    logic [3:0] a;
    logic signed [7:0] d;
    @(negedge clk);
    if (!rst_n) g = -1;
    else if (req0_valid && req1_valid) g = m_prio ? 1 : 0;
    else if (req0_valid) g = 0;
    else if (req1_valid) g = 1;
    else g = -1;
    e = m_en && rst_n;
    chk("ready0", 32'(req0_ready), 32'(g == 0));
    chk("ready1", 32'(req1_ready), 32'(g == 1));
    chk("wr_en", 32'(wr_en), 32'(e));
    chk("wr_addr", 32'(wr_addr), 32'(m_addr));
    chk("wr_data", wr_data, m_data);
    chk("hazard1", 32'(hazard1), 32'(e && rd_addr1 == m_addr));
    chk("hazard2", 32'(hazard2), 32'(e && rd_addr2 == m_addr));
    chk("last_grant", 32'(last_grant), 32'(m_last));
    a = (g == 1) ? req1_addr : req0_addr;
    d = (g == 1) ? req1_data : req0_data;
    m_gnt = g;
    @(posedge clk);
    if (e) m_mem[m_addr] = m_data;
    if (!rst_n) begin
      m_en = 0; m_prio = 0; m_last = 0; m_addr = '0; m_data = '0;
    end else if (g >= 0) begin
      m_en = !(ZP && a == 4'd0);
      m_addr = a;
      m_data = d;
      m_prio = (g == 0);
      m_last = (g == 1);
    end else begin
      m_en = 0;
    end
    #1;
  endtask

  task automatic raw_reset();
    rst_n = 0; rf_clr = 1;
    req0_valid = 0; req1_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    rf_clr = 0; rst_n = 1;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic v0; logic [3:0] a0; logic signed [7:0] d0;
    logic v1; logic [3:0] a1; logic signed [7:0] d1;
    logic [3:0] r1, r2;
    logic rdy0, rdy1, wen; logic [3:0] wa; logic signed [7:0] wd;
    logic h1, h2, lg; logic signed [7:0] rv;
  } vec_t;

  function automatic vec_t mk(
    input int v0, a0, d0, v1, a1, d1, r1, r2,
    input int e0, e1, ew, ewa, ewd, eh1, eh2, elg, erv
  );
    vec_t v;
    v.v0 = v0[0]; v.a0 = a0[3:0]; v.d0 = d0[7:0];
    v.v1 = v1[0]; v.a1 = a1[3:0]; v.d1 = d1[7:0];
    v.r1 = r1[3:0]; v.r2 = r2[3:0];
    v.rdy0 = e0[0]; v.rdy1 = e1[0]; v.wen = ew[0];
    v.wa = ewa[3:0]; v.wd = ewd[7:0];
    v.h1 = eh1[0]; v.h2 = eh2[0]; v.lg = elg[0]; v.rv = erv[7:0];
    return v;
  endfunction

  vec_t tv [14];

  bit                pend [2];
  int                wt   [2];

  initial begin
    rd_addr1 = '0; rd_addr2 = '0;
    req0_addr = '0; req1_addr = '0;
    req0_data = '0; req1_data = '0;
    raw_reset();

    // Reset state, with both requesters asserting valid during reset.
    rst_n = 0; req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    chk("rst_ready0", 32'(req0_ready), 0);
    chk("rst_ready1", 32'(req1_ready), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_hazard1", 32'(hazard1), 0);
    chk("rst_hazard2", 32'(hazard2), 0);
    chk("rst_last", 32'(last_grant), 0);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0; rst_n = 1;

    //        v0 a0  d0  v1 a1  d1  r1 r2 | r0 r1 we wa  wd  h1 h2 lg rv
    tv[0]  = mk(1, 3, -6, 0, 0,   0, 3, 0,  1, 0, 0, 0,   0, 0, 0, 0,  0);
    tv[1]  = mk(0, 0,  0, 0, 0,   0, 3, 3,  0, 0, 1, 3,  -6, 1, 1, 0,  0);
    tv[2]  = mk(0, 0,  0, 0, 0,   0, 3, 0,  0, 0, 0, 3,  -6, 0, 0, 0, -6);
    tv[3]  = mk(1, 1, 10, 1, 2, -20, 1, 2,  0, 1, 0, 3,  -6, 0, 0, 0,  0);
    tv[4]  = mk(1, 1, 10, 1, 2, -19, 1, 2,  1, 0, 1, 2, -20, 0, 1, 1,  0);
    tv[5]  = mk(1, 1, 11, 1, 2, -19, 1, 2,  0, 1, 1, 1,  10, 1, 0, 0,  0);
    tv[6]  = mk(1, 1, 11, 1, 2, -18, 1, 2,  1, 0, 1, 2, -19, 0, 1, 1, 10);
    tv[7]  = mk(0, 0,  0, 1, 2, -18, 5, 2,  0, 1, 1, 1,  11, 0, 0, 0,  0);
    tv[8]  = mk(1, 5,  7, 1, 5,  -7, 5, 2,  1, 0, 1, 2, -18, 0, 1, 1,  0);
    tv[9]  = mk(0, 0,  0, 1, 5,  -7, 5, 4,  0, 1, 1, 5,   7, 1, 0, 0,  0);
    tv[10] = mk(0, 0,  0, 0, 0,   0, 5, 5,  0, 0, 1, 5,  -7, 1, 1, 1,  7);
    tv[11] = mk(1, 4,  1, 0, 0,   0, 5, 2,  1, 0, 0, 5,  -7, 0, 0, 1, -7);
    tv[12] = mk(0, 0,  0, 0, 0,   0, 4, 2,  0, 0, 1, 4,   1, 1, 0, 0,  0);
    tv[13] = mk(0, 0,  0, 0, 0,   0, 4, 2,  0, 0, 0, 4,   1, 0, 0, 0,  1);

    for (int i = 0; i < 14; i++) begin
      req0_valid = tv[i].v0; req0_addr = tv[i].a0; req0_data = tv[i].d0;
      req1_valid = tv[i].v1; req1_addr = tv[i].a1; req1_data = tv[i].d1;
      rd_addr1 = tv[i].r1; rd_addr2 = tv[i].r2;
      @(negedge clk);
      chk($sformatf("t%0d_rdy0", i), 32'(req0_ready), 32'(tv[i].rdy0));
      chk($sformatf("t%0d_rdy1", i), 32'(req1_ready), 32'(tv[i].rdy1));
      chk($sformatf("t%0d_wen", i), 32'(wr_en), 32'(tv[i].wen));
      chk($sformatf("t%0d_waddr", i), 32'(wr_addr), 32'(tv[i].wa));
      chk($sformatf("t%0d_wdata", i), wr_data, tv[i].wd);
      chk($sformatf("t%0d_hz1", i), 32'(hazard1), 32'(tv[i].h1));
      chk($sformatf("t%0d_hz2", i), 32'(hazard2), 32'(tv[i].h2));
      chk($sformatf("t%0d_last", i), 32'(last_grant), 32'(tv[i].lg));
      chk($sformatf("t%0d_rf", i), rf[rd_addr1], tv[i].rv);
      @(posedge clk); #1;
    end
    req0_valid = 0; req1_valid = 0;

    // Reset arriving while a write is in flight.
    raw_reset();
    req0_valid = 1; req0_addr = 4'd6; req0_data = 8'sd33;
    tick();
    req0_valid = 0;
    req1_valid = 1; req1_addr = 4'd6; req1_data = -8'sd5;
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
    req1_valid = 0;
    chk("rst_cancel_rf6", rf[6], 0);
    tick();
    chk("post_rst_served_rf6", rf[6], -8'sd5);

    // Write to register 0.
    req0_valid = 1; req0_addr = 4'd0; req0_data = 8'sd9;
    tick();
    req0_valid = 0;
    tick();
    tick();
    chk("zero_reg_rf0", rf[0], ZP ? 8'sd0 : 8'sd9);
    chk("zero_reg_model", rf[0], m_mem[0]);

    // Randomized traffic with occasional resets.
    pend[0] = 0; pend[1] = 0; wt[0] = 0; wt[1] = 0;
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(63) != 0);
      if (!pend[0] && $urandom_range(3) != 0) begin
        pend[0] = 1; req0_valid = 1;
        req0_addr = 4'($urandom_range(15));
        req0_data = 8'($urandom_range(255));
      end
      if (!pend[1] && $urandom_range(3) != 0) begin
        pend[1] = 1; req1_valid = 1;
        req1_addr = 4'($urandom_range(15));
        req1_data = 8'($urandom_range(255));
      end
      rd_addr1 = ($urandom_range(1) != 0) ? m_addr : 4'($urandom_range(15));
      rd_addr2 = 4'($urandom_range(15));
      tick();
      for (int k = 0; k < 2; k++) begin
        if (m_gnt == k) begin
          chk($sformatf("fair%0d", k), 32'(wt[k] <= 1), 1);
          pend[k] = 0; wt[k] = 0;
          if (k == 0) req0_valid = 0; else req1_valid = 0;
        end else if (pend[k]) begin
          wt[k] = rst_n ? wt[k] + 1 : 0;
          if (wt[k] > 2) begin
            chk($sformatf("starve%0d", k), wt[k], 2);
            wt[k] = 0;
          end
        end
      end
    end
    rst_n = 1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (m_gnt == 0) req0_valid = 0;
      if (m_gnt == 1) req1_valid = 0;
    end
    for (int i = 0; i < 16; i++)
      chk($sformatf("final_rf%0d", i), rf[i], m_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
